rtl_kernel_wizard_1_axis_pattern_source: RTL

//   AXI4-Stream transmitter that drives the s_axis input of the float adder pipeline.
//   On a start pulse it emits ceil(LENGTH/LANES) beats of C_ELEM_WIDTH-bit lanes.

---
 rtl/axis_pattern_pkg.sv | 37 +++
 rtl/axis_pattern_if.sv | 31 +++
 rtl/axis_pattern_skid_buffer.sv | 61 ++++++
 rtl/rtl_kernel_wizard_1_axis_pattern_source.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_pkg.sv
// ---------------------------------------------------------------------------
// axis_pattern_pkg
//   Shared definitions for the AXI4-Stream pattern source:
//     - default widths, lane count and byte-per-lane constants
//     - FSM state encoding (IDLE, RUN, DONE)
//     - keep_for_count(n): byte-enable mask with the low n lanes enabled
// ---------------------------------------------------------------------------
package axis_pattern_pkg;

    localparam int unsigned AXIS_TDATA_WIDTH_DEF = 512;
    localparam int unsigned ELEM_WIDTH_DEF       = 32;
    localparam int unsigned LENGTH_WIDTH_DEF     = 32;
    localparam int unsigned LANES                = AXIS_TDATA_WIDTH_DEF / ELEM_WIDTH_DEF;
    localparam int unsigned ELEM_BYTES           = ELEM_WIDTH_DEF / 8;
    localparam int unsigned KEEP_W               = AXIS_TDATA_WIDTH_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte-enable mask covering the low n lanes (n is clipped by the caller to LANES).
    function automatic logic [KEEP_W-1:0] keep_for_count(input logic [31:0] n);
        logic [KEEP_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < int'(KEEP_W); b++) begin
            if (32'(b) < (n * 32'(ELEM_BYTES))) begin
                mask[b] = 1'b1;
            end else begin
                mask[b] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_pattern_if.sv
// ---------------------------------------------------------------------------
// axis_pattern_if
//   AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast).
//   master modport: drives tvalid, tdata, tkeep, tlast; samples tready.
//   slave  modport: the mirror image.
// ---------------------------------------------------------------------------
interface axis_pattern_if #(
    parameter int unsigned DATA_W = 512
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pattern_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_pattern_skid_buffer
//   2-entry AXI4-Stream register slice. s_ready depends only on local state,
//   so there is no combinational path from m_ready back to the producer.
//   Full throughput (1 beat/cycle) with m_ready held high.
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_valid/s_ready/s_payload   upstream side (payload = {tdata, tkeep, tlast})
//   m_valid/m_ready/m_payload   downstream side, all outputs registered
// ---------------------------------------------------------------------------
module axis_pattern_skid_buffer #(
    parameter int unsigned PAY_W = 577
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PAY_W-1:0] s_payload,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PAY_W-1:0] m_payload
);
    logic             out_valid_r;
    logic             skid_valid_r;
    logic [PAY_W-1:0] out_pay_r;
    logic [PAY_W-1:0] skid_pay_r;

    // Upstream may push only while the spare entry is empty.
    assign s_ready   = !skid_valid_r;
    assign m_valid   = out_valid_r;
    assign m_payload = out_pay_r;

    // Output entry refills from the spare first, then from upstream; a stalled
    // output parks the incoming beat in the spare entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_pay_r    <= '0;
            skid_pay_r   <= '0;
        end else if (!out_valid_r || m_ready) begin
            if (skid_valid_r) begin
                out_pay_r    <= skid_pay_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (s_valid) begin
                out_pay_r    <= s_payload;
                out_valid_r  <= 1'b1;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            if (s_valid && !skid_valid_r) begin
                skid_pay_r   <= s_payload;
                skid_valid_r <= 1'b1;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
        end
    end
endmodule

// File: rtl/rtl_kernel_wizard_1_axis_pattern_source.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_1_axis_pattern_source
//   AXI4-Stream pattern generator feeding the float adder s_axis input.
//   A start pulse in IDLE latches length/seed and emits ceil(length/LANES)
//   beats; lane j of beat k = seed + k*LANES + j (wrapping). The final beat
//   carries tlast and a keep mask covering only the valid lanes.
// Configuration macro
//   AXIS_PATTERN_SOURCE_SKID_EN : route the output through a 2-entry skid
//   buffer (no combinational tready path, first beat 2 cycles after start).
//   Undefined: single output register, first beat 1 cycle after start.
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   ctrl_start           start pulse, honoured only in IDLE
//   ctrl_length          element count (latched on accepted start)
//   ctrl_seed            value of element 0 (latched on accepted start)
//   ctrl_busy            high from accepted start until DONE ends
//   ctrl_done            1-cycle pulse after the final beat handshake
//   m_axis               AXI4-Stream master (tvalid/tready/tdata/tkeep/tlast)
// ---------------------------------------------------------------------------
module rtl_kernel_wizard_1_axis_pattern_source
    import axis_pattern_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
    parameter int unsigned C_ELEM_WIDTH       = ELEM_WIDTH_DEF,
    parameter int unsigned C_LENGTH_WIDTH     = LENGTH_WIDTH_DEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      ctrl_start,
    input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
    input  logic [C_ELEM_WIDTH-1:0]   ctrl_seed,
    output logic                      ctrl_busy,
    output logic                      ctrl_done,
    axis_pattern_if.master            m_axis
);
    localparam int unsigned LANES_L      = C_AXIS_TDATA_WIDTH / C_ELEM_WIDTH;
    localparam int unsigned KEEP_BYTES_L = C_AXIS_TDATA_WIDTH / 8;
    // One extra bit keeps length + LANES-1 and the element index from overflowing.
    localparam int unsigned IDX_W        = C_LENGTH_WIDTH + 1;

    typedef logic [C_ELEM_WIDTH-1:0] elem_t;
    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [KEEP_BYTES_L-1:0] keep_t;

    state_e                        state_r;
    idx_t                          len_r;
    idx_t                          nbeats_r;
    idx_t                          beat_r;
    idx_t                          elem_r;
    elem_t                         val_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          gen_valid_r;
    logic [C_AXIS_TDATA_WIDTH-1:0] gen_data_r;
    keep_t                         gen_keep_r;
    logic                          gen_last_r;

    logic                          gen_ready_s;
    logic                          out_valid_s;
    logic                          out_ready_s;
    logic                          out_last_s;

    idx_t                          start_len_s;
    idx_t                          start_nbeats_s;
    idx_t                          nxt_len_s;
    idx_t                          nxt_nbeats_s;
    idx_t                          nxt_beat_s;
    idx_t                          nxt_elem_s;
    idx_t                          remain_s;
    elem_t                         nxt_val_s;
    logic [31:0]                   lane_cnt_s;
    logic [C_AXIS_TDATA_WIDTH-1:0] nxt_data_s;
    keep_t                         nxt_keep_s;
    logic                          nxt_last_s;

    assign ctrl_busy = busy_r;
    assign ctrl_done = done_r;

    // Zero-extended length and ceil(length/LANES) for the start latch.
    always_comb begin
        start_len_s    = idx_t'(ctrl_length);
        start_nbeats_s = (start_len_s + idx_t'(LANES_L - 1)) / idx_t'(LANES_L);
    end

    // Content of the next beat to present: beat 0 from the control inputs
    // while idle, otherwise the successor of the beat currently held.
    always_comb begin
        if (state_r == ST_IDLE) begin
            nxt_len_s    = start_len_s;
            nxt_nbeats_s = start_nbeats_s;
            nxt_beat_s   = '0;
            nxt_elem_s   = '0;
            nxt_val_s    = ctrl_seed;
        end else begin
            nxt_len_s    = len_r;
            nxt_nbeats_s = nbeats_r;
            nxt_beat_s   = beat_r + idx_t'(1);
            nxt_elem_s   = elem_r + idx_t'(LANES_L);
            nxt_val_s    = val_r + elem_t'(LANES_L);
        end
        remain_s = nxt_len_s - nxt_elem_s;
        if (remain_s >= idx_t'(LANES_L)) begin
            lane_cnt_s = 32'(LANES_L);
        end else begin
            lane_cnt_s = 32'(remain_s);
        end
        nxt_data_s = '0;
        for (int j = 0; j < int'(LANES_L); j++) begin
            nxt_data_s[j*C_ELEM_WIDTH +: C_ELEM_WIDTH] = nxt_val_s + elem_t'(j);
        end
        nxt_keep_s = keep_t'(keep_for_count(lane_cnt_s));
        nxt_last_s = (nxt_beat_s == (nxt_nbeats_s - idx_t'(1)));
    end

`ifdef AXIS_PATTERN_SOURCE_SKID_EN
    localparam int unsigned PAY_W = C_AXIS_TDATA_WIDTH + KEEP_BYTES_L + 1;

    logic             skid_valid_s;
    logic [PAY_W-1:0] skid_pay_s;

    axis_pattern_skid_buffer #(
        .PAY_W (PAY_W)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_valid   (gen_valid_r),
        .s_ready   (gen_ready_s),
        .s_payload ({gen_data_r, gen_keep_r, gen_last_r}),
        .m_valid   (skid_valid_s),
        .m_ready   (m_axis.tready),
        .m_payload (skid_pay_s)
    );

    assign m_axis.tvalid = skid_valid_s;
    assign m_axis.tdata  = skid_pay_s[PAY_W-1 -: C_AXIS_TDATA_WIDTH];
    assign m_axis.tkeep  = skid_pay_s[KEEP_BYTES_L:1];
    assign m_axis.tlast  = skid_pay_s[0];
    assign out_valid_s   = skid_valid_s;
    assign out_last_s    = skid_pay_s[0];
`else
    assign gen_ready_s   = m_axis.tready;
    assign m_axis.tvalid = gen_valid_r;
    assign m_axis.tdata  = gen_data_r;
    assign m_axis.tkeep  = gen_keep_r;
    assign m_axis.tlast  = gen_last_r;
    assign out_valid_s   = gen_valid_r;
    assign out_last_s    = gen_last_r;
`endif
    assign out_ready_s = m_axis.tready;

    // Control FSM plus the generator output register.
    // DONE holds done_r for exactly one cycle; a zero-length job enters DONE
    // with done_r low so busy spans two cycles around its single done pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            nbeats_r    <= '0;
            beat_r      <= '0;
            elem_r      <= '0;
            val_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            gen_valid_r <= 1'b0;
            gen_data_r  <= '0;
            gen_keep_r  <= '0;
            gen_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (ctrl_start) begin
                        len_r    <= start_len_s;
                        nbeats_r <= start_nbeats_s;
                        busy_r   <= 1'b1;
                        if (start_len_s == idx_t'(0)) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r     <= ST_RUN;
                            gen_valid_r <= 1'b1;
                            gen_data_r  <= nxt_data_s;
                            gen_keep_r  <= nxt_keep_s;
                            gen_last_r  <= nxt_last_s;
                            beat_r      <= nxt_beat_s;
                            elem_r      <= nxt_elem_s;
                            val_r       <= nxt_val_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (gen_valid_r && gen_ready_s) begin
                        if (gen_last_r) begin
                            gen_valid_r <= 1'b0;
                            gen_data_r  <= '0;
                            gen_keep_r  <= '0;
                            gen_last_r  <= 1'b0;
                        end else begin
                            gen_valid_r <= 1'b1;
                            gen_data_r  <= nxt_data_s;
                            gen_keep_r  <= nxt_keep_s;
                            gen_last_r  <= nxt_last_s;
                            beat_r      <= nxt_beat_s;
                            elem_r      <= nxt_elem_s;
                            val_r       <= nxt_val_s;
                        end
                    end else begin
                        gen_valid_r <= gen_valid_r;
                    end
                    // Completion is judged at the stream output, after any buffering.
                    if (out_valid_s && out_ready_s && out_last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (done_r) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    gen_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
